// File: rtl/wb_axis_out_pkg.sv
// Shared constants, status layout and FSM encoding for the Wishbone-to-AXI-Stream
// output bridge (return path of the user-project FIR datapath).
package wb_axis_out_pkg;

    localparam logic [7:0] WIN_BASE = 8'h30;
    localparam logic [7:0] OFS_DATA = 8'h84;
    localparam logic [7:0] OFS_LEN  = 8'h14;
    localparam logic [7:0] OFS_STAT = 8'h8C;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_LAST   = 2;
    localparam int ST_ERR    = 3;
    localparam int ST_CNT_LO = 8;
    localparam int ST_CNT_HI = 12;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REG_ACK  = 2'd1,
        S_POP_WAIT = 2'd2
    } state_e;

    function automatic logic in_window(input logic [31:0] adr);
        return (adr[31:24] == WIN_BASE);
    endfunction

endpackage

// File: rtl/wb_axis_out_fifo.sv
// Synchronous circular FIFO with occupancy count; pointers wrap modulo DEPTH,
// which must be a power of two.
module wb_axis_out_fifo
    import wb_axis_out_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array write port.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Read/write pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_axis_out_bridge.sv
// Wishbone slave that drains FIR output samples from an AXI-Stream sink FIFO and
// exposes frame length, status and sticky frame-check flags.
module wb_axis_out_bridge
    import wb_axis_out_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   sm_tready
);

    localparam int CNT_W = $clog2(pDEPTH) + 1;

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [7:0]             ofs_r;
    logic                   we_r;
    logic [31:0]            wdat_r;
    logic [31:0]            data_len_r;
    logic [31:0]            rx_cnt_r;
    logic                   last_seen_r;
    logic                   tlast_err_r;
    logic                   hit_s;
    logic                   bus_held_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   reg_wr_s;
    logic                   stat_clr_s;
    logic                   frame_mismatch_s;
    logic [pDATA_WIDTH:0]   fifo_dout_s;
    logic                   full_s;
    logic                   empty_s;
    logic [CNT_W-1:0]       count_s;
    logic [31:0]            status_s;
    logic [31:0]            rd_data_s;
    logic                   unused_s;

    assign bus_held_s       = wbs_cyc_i & wbs_stb_i;
    assign hit_s            = bus_held_s & in_window(wbs_adr_i);
    assign sm_tready        = ~full_s;
    assign push_s           = sm_tvalid & sm_tready;
    assign pop_s            = (state_r == S_POP_WAIT) & bus_held_s & ~empty_s;
    assign reg_wr_s         = (state_r == S_REG_ACK) & we_r;
    assign stat_clr_s       = reg_wr_s & (ofs_r == OFS_STAT);
    assign frame_mismatch_s = sm_tlast ^ (rx_cnt_r == (data_len_r - 32'd1));
    assign unused_s         = ^{wbs_sel_i, wbs_adr_i[23:8], fifo_dout_s[pDATA_WIDTH]};

    wb_axis_out_fifo #(
        .WIDTH (pDATA_WIDTH + 1),
        .DEPTH (pDEPTH)
    ) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .push      (push_s),
        .pop       (pop_s),
        .din       ({sm_tlast, sm_tdata}),
        .dout      (fifo_dout_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Next-state decode; a dropped strobe in POP_WAIT abandons the pop.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (hit_s) begin
                    if ((wbs_adr_i[7:0] == OFS_DATA) && !wbs_we_i) begin
                        state_nxt_s = S_POP_WAIT;
                    end else begin
                        state_nxt_s = S_REG_ACK;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REG_ACK: state_nxt_s = S_IDLE;
            S_POP_WAIT: begin
                if (!bus_held_s || !empty_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_POP_WAIT;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM state and the request captured when it is accepted.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r <= S_IDLE;
            ofs_r   <= 8'h00;
            we_r    <= 1'b0;
            wdat_r  <= 32'h0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == S_IDLE) && hit_s) begin
                ofs_r  <= wbs_adr_i[7:0];
                we_r   <= wbs_we_i;
                wdat_r <= wbs_dat_i;
            end
        end
    end

    // Frame length register, beat counter and sticky flags; a new tlast beats a same-cycle clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            data_len_r  <= 32'h0;
            rx_cnt_r    <= 32'h0;
            last_seen_r <= 1'b0;
            tlast_err_r <= 1'b0;
        end else begin
            if (reg_wr_s && (ofs_r == OFS_LEN)) begin
                data_len_r <= wdat_r;
            end
            if (push_s) begin
                rx_cnt_r <= sm_tlast ? 32'h0 : (rx_cnt_r + 32'd1);
            end
            if (push_s && sm_tlast) begin
                last_seen_r <= 1'b1;
            end else if (stat_clr_s && wdat_r[ST_LAST]) begin
                last_seen_r <= 1'b0;
            end
            if (push_s && frame_mismatch_s) begin
                tlast_err_r <= 1'b1;
            end else if (stat_clr_s && wdat_r[ST_ERR]) begin
                tlast_err_r <= 1'b0;
            end
        end
    end

    // Status word assembly.
    always_comb begin
        status_s                      = 32'h0;
        status_s[ST_EMPTY]            = empty_s;
        status_s[ST_FULL]             = full_s;
        status_s[ST_LAST]             = last_seen_r;
        status_s[ST_ERR]              = tlast_err_r;
        status_s[ST_CNT_HI:ST_CNT_LO] = 5'(count_s);
    end

    // Read data mux; the bus sees zero whenever no ack is presented.
    always_comb begin
        rd_data_s = 32'h0;
        if ((state_r == S_REG_ACK) && !we_r) begin
            case (ofs_r)
                OFS_LEN:  rd_data_s = data_len_r;
                OFS_STAT: rd_data_s = status_s;
                default:  rd_data_s = 32'h0;
            endcase
        end else if (pop_s) begin
            rd_data_s = 32'(fifo_dout_s[pDATA_WIDTH-1:0]);
        end else begin
            rd_data_s = 32'h0;
        end
    end

    assign wbs_ack_o = (state_r == S_REG_ACK) | pop_s;
    assign wbs_dat_o = rd_data_s;

endmodule

// File: tb/tb_wb_axis_out_bridge.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed scenarios.
module tb_wb_axis_out_bridge;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]    sel = 4'hF;
    logic [31:0]   adr = 32'h0, wdat = 32'h0;
    logic          ack;
    logic [31:0]   rdat;
    logic          tvalid = 1'b0, tlast = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic          tready;

    int            n_cmp = 0;
    int            n_fail = 0;
    int unsigned   cyc_no = 0;
    int            simul_cnt = 0;

    // reference model state
    logic [32:0]   mq[$];
    logic          m_last = 1'b0, m_err = 1'b0;
    logic [31:0]   m_len = 32'h0, m_rx = 32'h0;
    logic          op_act = 1'b0, op_we = 1'b0;
    logic [31:0]   op_adr = 32'h0, op_wdat = 32'h0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    wb_axis_out_bridge #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .sm_tvalid (tvalid),
        .sm_tdata  (tdata),
        .sm_tlast  (tlast),
        .sm_tready (tready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = 32'h0;
        s[0]     = (mq.size() == 0);
        s[1]     = (mq.size() == DEPTH);
        s[2]     = m_last;
        s[3]     = m_err;
        s[12:8]  = 5'(mq.size());
        return s;
    endfunction

    // Compare DUT outputs with the model, then advance the model to the next edge.
    always @(negedge clk) begin
        logic popping, acc, set_last, set_err;
        if (!rst_n) begin
            mq.delete();
            m_last = 1'b0; m_err = 1'b0; m_len = 32'h0; m_rx = 32'h0;
            check("rst_ack", {31'h0, ack}, 32'h0);
            check("rst_dat", rdat, 32'h0);
            check("rst_tready", {31'h0, tready}, 32'h1);
        end else begin
            popping = 1'b0;
            check("tready", {31'h0, tready}, (mq.size() < DEPTH) ? 32'h1 : 32'h0);
            if (ack) begin
                if (!op_act || (op_adr[31:24] != 8'h30)) begin
                    check("spurious_ack", 32'h1, 32'h0);
                end else if (op_we) begin
                    check("wr_ack_dat", rdat, 32'h0);
                end else begin
                    case (op_adr[7:0])
                        8'h84: begin
                            if (mq.size() == 0) begin
                                check("pop_while_empty", 32'h1, 32'h0);
                            end else begin
                                check("pop_dat", rdat, mq[0][31:0]);
                                popping = 1'b1;
                            end
                        end
                        8'h14:   check("len_dat", rdat, m_len);
                        8'h8C:   check("stat_dat", rdat, m_status());
                        default: check("unmapped_dat", rdat, 32'h0);
                    endcase
                end
            end else begin
                check("idle_dat", rdat, 32'h0);
            end
            acc      = tvalid && tready;
            set_last = acc && tlast;
            set_err  = acc && (tlast != (m_rx == (m_len - 32'd1)));
            if (acc) m_rx = tlast ? 32'h0 : (m_rx + 32'd1);
            if (ack && op_act && op_we) begin
                if (op_adr[7:0] == 8'h14) m_len = op_wdat;
                if (op_adr[7:0] == 8'h8C) begin
                    if (op_wdat[2]) m_last = 1'b0;
                    if (op_wdat[3]) m_err = 1'b0;
                end
            end
            if (set_last) m_last = 1'b1;
            if (set_err) m_err = 1'b1;
            if (popping) void'(mq.pop_front());
            if (popping && acc) simul_cnt++;
            if (acc) mq.push_back({tlast, tdata});
        end
    end

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input int budget,
                           output logic [31:0] rd, output bit acked, output int unsigned ack_cyc);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d;
        op_act = 1'b1; op_we = w; op_adr = a; op_wdat = d;
        acked = 1'b0; rd = 32'h0; ack_cyc = 0;
        for (int i = 0; i < budget && !acked; i++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1'b1; rd = rdat; ack_cyc = cyc_no;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        op_act = 1'b0;
    endtask

    task automatic wb_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; bit ok; int unsigned c;
        wb_xfer(a, 1'b0, 32'h0, 200, rd, ok, c);
        check({name, "_ack"}, {31'h0, ok}, 32'h1);
        check(name, rd, exp);
    endtask

    task automatic wb_write(input string name, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; bit ok; int unsigned c;
        wb_xfer(a, 1'b1, d, 20, rd, ok, c);
        check({name, "_ack"}, {31'h0, ok}, 32'h1);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, output int unsigned acc_cyc);
        bit ok;
        @(posedge clk); #1;
        tvalid = 1'b1; tdata = d; tlast = last; ok = 1'b0; acc_cyc = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (tready) begin
                ok = 1'b1; acc_cyc = cyc_no;
            end
        end
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
        if (!ok) check("beat_timeout", 32'h0, 32'h1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd; bit ok; int unsigned c, acc_c, ack_c;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // out of reset
        check("init_tready", {31'h0, tready}, 32'h1);
        wb_read("init_stat", 32'h3000_008C, 32'h0000_0001);
        wb_read("init_len", 32'h3000_0014, 32'h0);

        // reset mid-stream with 3 words buffered
        wb_write("len5_wr", 32'h3000_0014, 32'h5);
        wb_read("len5_rd", 32'h3000_0014, 32'h5);
        for (int i = 0; i < 3; i++) send_beat(32'h10 + i, 1'b0, c);
        wb_read("three_stat", 32'h3000_008C, 32'h0000_0300);
        do_reset();
        wb_read("post_rst_stat", 32'h3000_008C, 32'h0000_0001);
        wb_read("post_rst_len", 32'h3000_0014, 32'h0);
        check("post_rst_tready", {31'h0, tready}, 32'h1);

        // fill to full, fifth beat stalls
        for (int i = 0; i < 4; i++) send_beat(32'hA0 + i, 1'b0, c);
        @(posedge clk); #1;
        tvalid = 1'b1; tdata = 32'hA4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_stall", {31'h0, tready}, 32'h0);
        end
        @(posedge clk); #1 tvalid = 1'b0;
        wb_read("full_stat", 32'h3000_008C, 32'h0000_0402);
        for (int i = 0; i < 4; i++) wb_read("fill_pop", 32'h3000_0084, 32'hA0 + i);

        // pop while empty, beat arrives 5 cycles later
        fork
            wb_xfer(32'h3000_0084, 1'b0, 32'h0, 40, rd, ok, ack_c);
            begin
                repeat (5) @(posedge clk);
                send_beat(32'h1234, 1'b0, acc_c);
            end
        join
        check("wait_ack", {31'h0, ok}, 32'h1);
        check("wait_dat", rd, 32'h1234);
        check("wait_latency", ack_c, acc_c + 1);

        // simultaneous push/pop across pointer wrap
        send_beat(32'hB0, 1'b0, c);
        send_beat(32'hB1, 1'b0, c);
        fork
            for (int i = 0; i < 20; i++) send_beat(32'hC00 + i, 1'b0, c);
            for (int j = 0; j < 20; j++)
                wb_read("wrap_pop", 32'h3000_0084, (j < 2) ? (32'hB0 + j) : (32'hC00 + j - 2));
        join
        wb_read("wrap_stat", 32'h3000_008C, 32'h0000_0200);
        check("simul_seen", (simul_cnt > 0) ? 32'h1 : 32'h0, 32'h1);

        // frame length checking
        do_reset();
        wb_write("len8_wr", 32'h3000_0014, 32'h8);
        fork
            for (int i = 0; i < 8; i++) send_beat(32'hF0 + i, (i == 7), c);
            for (int j = 0; j < 8; j++) wb_read("frame_pop", 32'h3000_0084, 32'hF0 + j);
        join
        wb_read("frame_ok_stat", 32'h3000_008C, 32'h0000_0005);
        fork
            for (int i = 0; i < 3; i++) send_beat(32'hE0 + i, (i == 2), c);
            for (int j = 0; j < 3; j++) wb_read("frame2_pop", 32'h3000_0084, 32'hE0 + j);
        join
        wb_read("frame_err_stat", 32'h3000_008C, 32'h0000_000D);
        wb_write("w1c_wr", 32'h3000_008C, 32'h0000_000C);
        wb_read("w1c_stat", 32'h3000_008C, 32'h0000_0001);

        // unmapped and out-of-window accesses
        wb_read("unmapped_rd", 32'h3000_0040, 32'h0);
        wb_write("unmapped_wr", 32'h3000_0040, 32'hDEAD_BEEF);
        send_beat(32'h55, 1'b0, c);
        wb_xfer(32'h2000_0084, 1'b0, 32'h0, 8, rd, ok, c);
        check("oow_no_ack", {31'h0, ok}, 32'h0);
        wb_read("oow_stat", 32'h3000_008C, 32'h0000_0100);
        wb_read("oow_pop", 32'h3000_0084, 32'h55);

        // master abandons a pop wait
        wb_xfer(32'h3000_0084, 1'b0, 32'h0, 4, rd, ok, c);
        check("abandon_no_ack", {31'h0, ok}, 32'h0);
        send_beat(32'h77, 1'b0, c);
        repeat (2) @(posedge clk);
        wb_read("abandon_stat", 32'h3000_008C, 32'h0000_0100);
        wb_read("abandon_pop", 32'h3000_0084, 32'h77);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_axis_out_bridge.md
# wb_axis_out_bridge

Wishbone-slave-to-AXI-Stream-sink bridge: the return path of the user-project FIR datapath. Accepts output samples on the AXI-Stream master side of the FIR (`sm_*`), buffers them with their `tlast` flag in a small FIFO, and lets firmware pop samples and poll status over Wishbone. It complements the stream-input bridge and shares its `0x30xx_xxxx` user address window.

## Interface
- `pDATA_WIDTH`, 32, stream/bus data width
- `pDEPTH`, 4, output FIFO depth; must be a power of two, 2..16
- `wb_clk_i`  in  1  sole clock
- `wb_rst_ni`  in  1  asynchronous, active-low reset
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1  Wishbone strobe, cycle and write-enable
- `wbs_sel_i`  in  4  byte select; ignored, full-word access only
- `wbs_adr_i`  in  32  address
- `wbs_dat_i`  in  32  write data
- `wbs_ack_o`  out  1  acknowledge
- `wbs_dat_o`  out  32  read data; valid only while `wbs_ack_o` is high, 0 otherwise
- `sm_tvalid`  in  1  stream valid from the FIR
- `sm_tdata`  in  pDATA_WIDTH  stream data
- `sm_tlast`  in  1  last sample of frame
- `sm_tready`  out  1  `~full`

## Operation
- Decode: `hit = cyc & stb & (adr[31:24]==8'h30)`. The register offset is `adr[7:0]`.
- Register map:
  - `0x84` R: pop the FIFO head; returns its data. W: ignored, acked.
  - `0x14` R/W: `data_len`, 32-bit expected frame length; reset value 0.
  - `0x8C` R: status. W: write-1-to-clear for bits 2 and 3.
  - Any other offset inside the window: acked; reads return 0; writes are ignored, so the bus never hangs.
- Status bits:
  - [0] `empty`
  - [1] `full`
  - [2] `last_seen`, sticky; set when a beat with `tlast` is accepted
  - [3] `tlast_err`, sticky; set when accepted `tlast` disagrees with `rx_cnt == data_len-1`
  - [12:8] `count`
  - all other bits 0
- Stream sink:
  - Beat accepted when `sm_tvalid & sm_tready`.
  - FIFO word is `{tlast, tdata}`.
  - `rx_cnt` (32-bit) increments per accepted beat and clears to 0 on an accepted `tlast`.
- FSM states: IDLE, REG_ACK, POP_WAIT.
  - IDLE: on `hit` at offset `0x84` with `we=0`, go to POP_WAIT. On any other `hit`, go to REG_ACK.
  - REG_ACK: `wbs_ack_o=1` for exactly one cycle. Perform the register write or drive the read data. Return to IDLE.
  - POP_WAIT: if `~empty`, then `wbs_ack_o=1`, `wbs_dat_o=head data`, pop, and return to IDLE. If empty, hold with `ack=0` (wait-state) until data arrives.
  - Firmware polls status bit 0 first to avoid long stalls.
- Simultaneous push and pop in the same cycle: both take effect and `count` is unchanged.
- Pointers wrap modulo `pDEPTH`. `count` ranges 0..`pDEPTH`.
- Write to `0x8C` with bits 2 and 3 set, in the same cycle as a new `tlast` accept: the set wins.
- Bus master dropping `stb`/`cyc` while in POP_WAIT: return to IDLE with no pop and no ack.

## Timing
- Reset (async assert, sync deassert assumed at the SoC level) clears:
  - FSM to IDLE
  - FIFO pointers, `count`, `rx_cnt`, `data_len`, sticky bits to 0
  - outputs: `wbs_ack_o=0`, `wbs_dat_o=0`, `sm_tready=1`
- Reset mid-transaction discards buffered data and any pending ack.
- Register access latency: request seen at cycle t, ack at t+1 (one wait state).
- Pop latency:
  - With a non-empty FIFO, ack at t+1.
  - When empty, ack in the cycle after the first accepted beat: a beat accepted at cycle u gives ack at u+1. There is no FIFO bypass.
- `sm_tready` is combinational from `count` only. When full, a pop in cycle t raises `sm_tready` at t+1.
- Status reads return the value registered at the ack cycle.

## Structure
- Package `wb_axis_out_pkg`:
  - offset constants `OFS_DATA=8'h84`, `OFS_LEN=8'h14`, `OFS_STAT=8'h8C`
  - status bit indices
  - FSM state enum
  - window base `8'h30`
- Sub-module `wb_axis_out_fifo`: synchronous circular FIFO.
  - Parameters: `WIDTH=pDATA_WIDTH+1`, `DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
  - Same clock and reset as the top.
- Top level: decode, FSM, `data_len`, `rx_cnt`, sticky bits and read mux.

## Test plan
- Reset: drive `wb_rst_ni=0` mid-stream with 3 words buffered → after release, status reads `0x0000_0001`, `sm_tready=1`, `data_len=0`.
- Fill/full: push 4 beats `0xA0..0xA3` with no reads → 5th beat stalls (`sm_tready=0`). Status = `0x0000_0402`. Pops return `A0, A1, A2, A3` in order.
- Empty pop wait: read `0x84` while empty, then push `0x1234` 5 cycles later → ack arrives exactly 1 cycle after the beat is accepted, with data `0x1234`. No ack before that.
- Simultaneous: FIFO holds 2; push and pop in the same cycle → count stays 2 and order is preserved across pointer wrap (run 20 beats).
- Frame check: `data_len=8`, send 8 beats with `tlast` on the 8th → `last_seen=1`, `tlast_err=0`. Send `tlast` on the 3rd beat of the next frame → `tlast_err=1`. Write `0x0C` to `0x8C` → both bits clear.
- Unmapped and out-of-window accesses: read `0x3000_0040` → ack, data 0. Access `0x2000_0084` → no ack and no pop.
